alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter NB_DATA, default 8, SHALL set the operand/result width (legal range 4..32).
REQ-002 Parameter NB_OP, default 6, SHALL set the opcode width (NB_OP <= NB_DATA).
REQ-003 Parameter DBNC_CYCLES, default 4, SHALL set the debounce stable-count length (legal range 2..2^20).
REQ-004 Port i_clk  in  1  SHALL be the clock; all logic is rising-edge.
REQ-005 Port i_reset  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 Port i_sw  in  NB_DATA  SHALL be the switch data bus (asynchronous to i_clk, quasi-static).
REQ-007 Port i_btn_next  in  1  SHALL be the raw "advance/load" push-button (asynchronous, bouncing).
REQ-008 Port i_btn_clear  in  1  SHALL be the raw "clear" push-button (asynchronous, bouncing).
REQ-009 Port o_res  out  NB_DATA  SHALL be the registered ALU result.
REQ-010 Port o_carry / o_zero / o_ovf  out  1 each  SHALL be the registered carry, zero and signed-overflow flags.
REQ-011 Port o_valid  out  1  SHALL be high while o_res/flags hold a completed result.
REQ-012 Port o_state  out  3  SHALL expose the current FSM state encoding.

Function
REQ-013 Each button SHALL pass through a 2-FF synchroniser, then a debouncer whose level changes only after the synchronised input is stable at the new value for DBNC_CYCLES consecutive cycles.
REQ-014 A "press" SHALL be a one-cycle pulse on the debounced 0->1 edge; holding a button SHALL yield exactly one press.
REQ-015 FSM states SHALL be S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4; encodings 5..7 SHALL transition to S_A on the next cycle.
REQ-016 S_A: on next-press, A <= i_sw, go S_B. S_B: on next-press, B <= i_sw, go S_OP.
REQ-017 S_OP: on next-press, OP <= i_sw[NB_OP-1:0], go S_EXEC.
REQ-018 S_EXEC SHALL last exactly one cycle: result and flags registered, o_valid <= 1, go S_SHOW; o_valid rises 2 cycles after the OP press pulse.
REQ-019 S_SHOW: outputs held; on next-press, o_valid <= 0, go S_A with A/B/OP retained until reloaded.
REQ-020 Clear-press in any state SHALL go to S_A, zero A, B, OP, o_res, all flags and o_valid on the next edge; clear SHALL win over a simultaneous next-press.
REQ-021 Presses arriving in S_EXEC SHALL be ignored (not queued).
REQ-022 Opcodes (NB_OP=6): ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRA 000011, SRL 000010; for NB_OP>6 the upper bits SHALL be zero for a match.
REQ-023 ADD: o_carry = unsigned carry-out of A+B; o_ovf = two's-complement overflow.
REQ-024 SUB: o_res = A-B mod 2^NB_DATA; o_carry = 1 iff A < B unsigned (borrow); o_ovf = two's-complement overflow.
REQ-025 Logic ops SHALL set o_carry = o_ovf = 0.
REQ-026 SRL/SRA shift A right by unsigned B; B >= NB_DATA SHALL give all-zeros (SRL) or all copies of A[MSB] (SRA); o_carry = o_ovf = 0.
REQ-027 Undefined opcode SHALL give o_res = 0, o_carry = o_ovf = 0, o_valid = 1.
REQ-028 o_zero SHALL equal (o_res == 0) for every completed result.

Reset
REQ-029 While i_reset is high at an edge: state S_A, A = B = OP = 0, o_res = 0, o_carry = o_ovf = o_zero = o_valid = 0, o_state = 0, synchronisers/debouncers/edge detectors cleared (debounced level 0).
REQ-030 A button held through reset release SHALL NOT produce a press until released and pressed again.
REQ-031 Reset asserted in S_EXEC or S_SHOW SHALL discard the result (o_valid = 0 next cycle).

Verification (NB_DATA=8, NB_OP=6, DBNC_CYCLES=4)
REQ-032 A=0xFF, B=0x01, OP=ADD -> o_res=0x00, o_carry=1, o_zero=1, o_ovf=0, o_valid=1.
REQ-033 A=0x7F, B=0x01, ADD -> 0x80, ovf=1, carry=0; A=0x03, B=0x05, SUB -> 0xFE, carry=1, ovf=0.
REQ-034 A=0x80, B=0x09, SRA -> 0xFF; same with SRL -> 0x00, zero=1.
REQ-035 i_btn_next toggling every cycle for 20 cycles, then stable high 10 cycles -> exactly one press, state advances by one.
REQ-036 In S_OP, clear and next pressed on the same cycle -> S_A, A=B=OP=0, o_valid=0; opcode 0x3F -> o_res=0, o_zero=1, o_valid=1.
REQ-037 Reset pulsed in S_SHOW with button held -> S_A, all outputs 0, no press until button released and re-pressed.

Source files
------------

// File: rtl/alu_sequencer.sv
// Switch-driven ALU sequencer: debounced buttons step through A, B and opcode entry,
// then one execute cycle registers the result and flags for display.
module alu_sequencer #(
   parameter int unsigned NB_DATA     = 8,
   parameter int unsigned NB_OP       = 6,
   parameter int unsigned DBNC_CYCLES = 4
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_sw,
   input  logic               i_btn_next,
   input  logic               i_btn_clear,
   output logic [NB_DATA-1:0] o_res,
   output logic               o_carry,
   output logic               o_zero,
   output logic               o_ovf,
   output logic               o_valid,
   output logic [2:0]         o_state
);

   localparam int unsigned     CNT_W    = (DBNC_CYCLES > 1) ? $clog2(DBNC_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBNC_CYCLES - 1);
   localparam int unsigned     MSB      = NB_DATA - 1;

   localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
   localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
   localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
   localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
   localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
   localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
   localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
   localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_SHOW = 3'd4
   } state_t;

   // Bit 0 = next button, bit 1 = clear button
   logic [1:0]       raw, sync1, sync2, level, level_d, armed, press;
   logic [CNT_W-1:0] cnt [2];

   state_t             state, state_next;
   logic [NB_DATA-1:0] a, b;
   logic [NB_OP-1:0]   op;
   logic               ld_a, ld_b, ld_op, ld_res, drop_res, clr_all;

   logic [NB_DATA:0]   sum, diff;
   logic [NB_DATA-1:0] alu_res;
   logic               alu_carry, alu_ovf, shift_big;

   assign raw   = {i_btn_clear, i_btn_next};
   assign press = level & ~level_d;

   // Synchroniser + debouncer; a button is disarmed after reset until seen released
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync1   <= '0;
         sync2   <= '0;
         level   <= '0;
         level_d <= '0;
         armed   <= '0;
         for (int i = 0; i < 2; i++) cnt[i] <= '0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_d <= level;
         for (int i = 0; i < 2; i++) begin
            if (!armed[i]) begin
               if (sync2[i]) begin
                  cnt[i] <= '0;
               end else if (cnt[i] == CNT_LAST) begin
                  armed[i] <= 1'b1;
                  cnt[i]   <= '0;
               end else begin
                  cnt[i] <= cnt[i] + CNT_W'(1);
               end
            end else if (sync2[i] == level[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               level[i] <= sync2[i];
               cnt[i]   <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) state <= S_A;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (press[1]) begin
         state_next = S_A;
      end else begin
         case (state)
            S_A:     if (press[0]) state_next = S_B;
            S_B:     if (press[0]) state_next = S_OP;
            S_OP:    if (press[0]) state_next = S_EXEC;
            S_EXEC:  state_next = S_SHOW;
            S_SHOW:  if (press[0]) state_next = S_A;
            default: state_next = S_A;
         endcase
      end
   end

   always_comb begin
      ld_a     = 1'b0;
      ld_b     = 1'b0;
      ld_op    = 1'b0;
      ld_res   = 1'b0;
      drop_res = 1'b0;
      clr_all  = press[1];
      if (!press[1]) begin
         case (state)
            S_A:     ld_a     = press[0];
            S_B:     ld_b     = press[0];
            S_OP:    ld_op    = press[0];
            S_EXEC:  ld_res   = 1'b1;
            S_SHOW:  drop_res = press[0];
            default: ;
         endcase
      end
   end

   always_comb begin
      sum       = {1'b0, a} + {1'b0, b};
      diff      = {1'b0, a} - {1'b0, b};
      shift_big = 32'(b) >= NB_DATA;
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res   = sum[NB_DATA-1:0];
            alu_carry = sum[NB_DATA];
            alu_ovf   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
         end
         OP_SUB: begin
            alu_res   = diff[NB_DATA-1:0];
            alu_carry = diff[NB_DATA];
            alu_ovf   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
         end
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_XOR: alu_res = a ^ b;
         OP_NOR: alu_res = ~(a | b);
         OP_SRL: alu_res = shift_big ? '0 : (a >> b);
         OP_SRA: alu_res = shift_big ? {NB_DATA{a[MSB]}} : NB_DATA'($signed(a) >>> b);
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset || clr_all) begin
         a       <= '0;
         b       <= '0;
         op      <= '0;
         o_res   <= '0;
         o_carry <= 1'b0;
         o_zero  <= 1'b0;
         o_ovf   <= 1'b0;
         o_valid <= 1'b0;
      end else begin
         if (ld_a)  a  <= i_sw;
         if (ld_b)  b  <= i_sw;
         if (ld_op) op <= i_sw[NB_OP-1:0];
         if (ld_res) begin
            o_res   <= alu_res;
            o_carry <= alu_carry;
            o_zero  <= (alu_res == '0);
            o_ovf   <= alu_ovf;
            o_valid <= 1'b1;
         end else if (drop_res) begin
            o_valid <= 1'b0;
         end
      end
   end

   assign o_state = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised bench for alu_sequencer: bouncing button presses, integer ALU reference model.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] sw = '0;
   logic       btn_next = 1'b0;
   logic       btn_clear = 1'b0;
   logic [7:0] res;
   logic       carry, zero, ovf, valid;
   logic [2:0] state;

   int errors = 0;
   int checks = 0;
   bit pend_show = 1'b0;

   alu_sequencer #(.NB_DATA(8), .NB_OP(6), .DBNC_CYCLES(4)) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_sw       (sw),
      .i_btn_next (btn_next),
      .i_btn_clear(btn_clear),
      .o_res      (res),
      .o_carry    (carry),
      .o_zero     (zero),
      .o_ovf      (ovf),
      .o_valid    (valid),
      .o_state    (state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge and watch the execute step
   task automatic tick();
      @(negedge clk);
      if (pend_show) begin
         check("exec_one_cycle", 32'(state), 32'd4);
         check("valid_at_show", 32'(valid), 32'd1);
         pend_show = 1'b0;
      end
      if (state == 3'd3) begin
         check("valid_low_in_exec", 32'(valid), 32'd0);
         pend_show = 1'b1;
      end
   endtask

   task automatic press(input bit clr, input bit nxt, input int bounce);
      for (int i = 0; i < bounce; i++) begin
         if (nxt) btn_next = 1'($urandom);
         if (clr) btn_clear = 1'($urandom);
         tick();
      end
      if (nxt) btn_next = 1'b1;
      if (clr) btn_clear = 1'b1;
      repeat (12) tick();
      btn_next  = 1'b0;
      btn_clear = 1'b0;
      repeat (12) tick();
   endtask

   function automatic int sgn(input int x);
      return (x >= 128) ? x - 256 : x;
   endfunction

   function automatic void ref_alu(input int a, input int b, input int op,
                                   output int r, output int c, output int z, output int v);
      int s;
      r = 0; c = 0; v = 0;
      case (op)
         'h20: begin
            r = (a + b) & 255; c = (a + b > 255) ? 1 : 0;
            s = sgn(a) + sgn(b); v = (s > 127 || s < -128) ? 1 : 0;
         end
         'h22: begin
            r = (a - b) & 255; c = (a < b) ? 1 : 0;
            s = sgn(a) - sgn(b); v = (s > 127 || s < -128) ? 1 : 0;
         end
         'h24: r = a & b;
         'h25: r = a | b;
         'h26: r = a ^ b;
         'h27: r = (~(a | b)) & 255;
         'h02: r = (b >= 8) ? 0 : (a >> b);
         'h03: r = (b >= 8) ? ((a >= 128) ? 255 : 0) : ((sgn(a) >>> b) & 255);
         default: r = 0;
      endcase
      z = (r == 0) ? 1 : 0;
   endfunction

   task automatic run_op(input int a, input int b, input int op);
      int r, c, z, v;
      if (state == 3'd4) begin
         press(1'b0, 1'b1, int'($urandom_range(0, 6)));
         check("show_to_a", 32'(state), 32'd0);
         check("show_drop_valid", 32'(valid), 32'd0);
      end
      sw = 8'(a); press(1'b0, 1'b1, int'($urandom_range(0, 6))); sw = 8'($urandom);
      check("state_b", 32'(state), 32'd1);
      sw = 8'(b); press(1'b0, 1'b1, int'($urandom_range(0, 6))); sw = 8'($urandom);
      check("state_op", 32'(state), 32'd2);
      sw = 8'(op); press(1'b0, 1'b1, int'($urandom_range(0, 6))); sw = 8'($urandom);
      ref_alu(a, b, op, r, c, z, v);
      check("state_show", 32'(state), 32'd4);
      check("valid", 32'(valid), 32'd1);
      check("res", 32'(res), 32'(r));
      check("carry", 32'(carry), 32'(c));
      check("zero", 32'(zero), 32'(z));
      check("ovf", 32'(ovf), 32'(v));
   endtask

   initial begin
      int ops[8] = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h27, 'h02, 'h03};
      int a, b, op;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_state", 32'(state), 32'd0);
      check("rst_res", 32'(res), 32'd0);
      check("rst_carry", 32'(carry), 32'd0);
      check("rst_zero", 32'(zero), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      repeat (12) tick();

      run_op('hFF, 'h01, 'h20);
      run_op('h7F, 'h01, 'h20);
      run_op('h03, 'h05, 'h22);
      run_op('h80, 'h09, 'h03);
      run_op('h80, 'h09, 'h02);
      run_op('hA5, 'h5A, 'h3F);
      run_op('hC0, 'h03, 'h03);
      run_op('h80, 'h80, 'h20);

      for (int i = 0; i < 12; i++) begin
         a  = int'($urandom_range(0, 255));
         op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : int'($urandom_range(0, 63));
         b  = (op == 'h02 || op == 'h03) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 255));
         run_op(a, b, op);
      end

      // Clear while showing a nonzero result
      run_op('h12, 'h34, 'h20);
      press(1'b1, 1'b0, 3);
      check("clr_state", 32'(state), 32'd0);
      check("clr_res", 32'(res), 32'd0);
      check("clr_valid", 32'(valid), 32'd0);
      check("clr_zero", 32'(zero), 32'd0);

      // Chatter that never settles, then a clean hold: one press only
      sw = 8'h5A;
      for (int i = 0; i < 20; i++) begin
         btn_next = ~btn_next;
         tick();
      end
      btn_next = 1'b1;
      repeat (10) tick();
      btn_next = 1'b0;
      repeat (12) tick();
      check("bounce_one_press", 32'(state), 32'd1);

      // Clear and next together in S_OP: clear wins
      press(1'b0, 1'b1, 0);
      check("reach_op", 32'(state), 32'd2);
      press(1'b1, 1'b1, 0);
      check("clr_wins_state", 32'(state), 32'd0);
      check("clr_wins_valid", 32'(valid), 32'd0);
      check("clr_wins_res", 32'(res), 32'd0);

      // Reset in S_SHOW with the next button held
      run_op('h55, 'h0F, 'h24);
      btn_next = 1'b1;
      reset    = 1'b1;
      tick();
      check("rst_show_valid", 32'(valid), 32'd0);
      tick();
      reset = 1'b0;
      repeat (20) tick();
      check("held_state", 32'(state), 32'd0);
      check("held_res", 32'(res), 32'd0);
      check("held_valid", 32'(valid), 32'd0);
      btn_next = 1'b0;
      repeat (12) tick();
      check("release_no_press", 32'(state), 32'd0);
      run_op('h21, 'h12, 'h26);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
